// File: rtl/pinwheel_pkg.sv
// pinwheel_pkg: shared RAM types and dumper state encoding for the pinwheel data RAM
package pinwheel_pkg;
  localparam int RAM_AW = 10;
  localparam int RAM_DW = 32;
  typedef logic [RAM_AW-1:0] ram_addr_t;
  typedef logic [RAM_DW-1:0] ram_word_t;
  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_CAPTURE, ST_SEND, ST_DONE} dumper_state_e;
endpackage

// File: rtl/pinwheel_ram.sv
// pinwheel_ram: 32x1024 data RAM, one write port and one registered read port
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out one cycle later.
module pinwheel_ram
  import pinwheel_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  ram_addr_t waddr,
  input  ram_word_t wdata,
  input  ram_addr_t raddr,
  output ram_word_t rdata
);
  ram_word_t mem_q [2**RAM_AW];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end
endmodule

// File: rtl/pinwheel_ram_dumper.sv
// pinwheel_ram_dumper: reads a word block from the pinwheel RAM and streams it LSB-first as bytes
// Ports: clk, rst_n (sync, active-low); start/base_addr/word_count command;
// busy/done/checksum status; raddr/rdata RAM read port; out_data/out_valid/out_ready byte stream.
module pinwheel_ram_dumper
  import pinwheel_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            checksum,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  dumper_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            sum_q, sum_d;
  logic                  hs;
  assign hs        = out_valid && out_ready;
  assign raddr     = addr_q;
  assign out_data  = shift_q[7:0];
  assign out_valid = state_q == ST_SEND;
  assign busy      = state_q inside {ST_READ, ST_CAPTURE, ST_SEND};
  assign done      = state_q == ST_DONE;
  assign checksum  = sum_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: if (start) begin
        sum_d   = '0;
        state_d = word_count != '0 ? ST_READ : ST_DONE;
        if (word_count != '0) begin
          addr_d = base_addr;
          cnt_d  = word_count;
        end
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        shift_d = rdata;
        idx_d   = '0;
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: if (hs) begin
        sum_d   = sum_q + shift_q[7:0];
        shift_d = shift_q >> 8;
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = cnt_q != '0 ? ST_READ : ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end
endmodule

// File: tb/tb_pinwheel_ram_dumper.sv
// tb_pinwheel_ram_dumper: randomized and directed bench for the RAM dumper against a byte-stream model
module tb_pinwheel_ram_dumper;
  logic        clk = 0;
  logic        rst_n, start, we, out_ready;
  logic [9:0]  base_addr, raddr, waddr;
  logic [10:0] word_count;
  logic        busy, done, out_valid;
  logic [7:0]  checksum, out_data;
  logic [31:0] rdata, wdata;
  logic [31:0] model_mem [1024];
  int checks = 0;
  int failures = 0;
  int dc;

  always #5 clk = ~clk;

  pinwheel_ram u_ram (.clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata));

  pinwheel_ram_dumper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .checksum(checksum), .raddr(raddr), .rdata(rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic write_word(input int a, input logic [31:0] d);
    we = 1; waddr = 10'(a); wdata = d; model_mem[a] = d;
    @(posedge clk); #1;
    we = 0;
  endtask

  task automatic run_cmd(input int base, input int count, input int mode, input bit inject, output int done_cyc);
    logic [7:0] exp_b[$];
    logic [7:0] got[$];
    logic [9:0] exp_a[$];
    logic [9:0] got_a[$];
    logic [7:0] exp_sum, pd;
    logic [31:0] w;
    int stalls, hold, bad, exp_done;
    bit pv, phs, pbnv, seen, r;
    exp_sum = 0; pd = 0; stalls = 0; hold = 0; pv = 0; phs = 0; pbnv = 0; seen = 0;
    for (int i = 0; i < count; i++) begin
      exp_a.push_back(10'((base + i) % 1024));
      w = model_mem[(base + i) % 1024];
      for (int b = 0; b < 4; b++) begin
        exp_b.push_back(w[8*b +: 8]);
        exp_sum = exp_sum + w[8*b +: 8];
      end
    end
    done_cyc = -1;
    start = 1; base_addr = 10'(base); word_count = 11'(count); out_ready = 1;
    for (int cyc = 1; cyc <= 20 * count + 50 && !seen; cyc++) begin
      @(posedge clk); #1;
      start = inject && cyc == 3;
      if (inject && cyc == 3) begin base_addr = 0; word_count = 4; end
      if (pv && !phs) begin
        checks++;
        if (!(out_valid === 1'b1 && out_data === pd)) begin
          failures++;
          $display("FAIL hold_stable cyc=%0d got valid=%b data=%h want valid=1 data=%h", cyc, out_valid, out_data, pd);
        end
      end
      case (mode)
        0: r = 1;
        1: r = $urandom_range(3, 0) != 0;
        default: begin
          r = !(out_valid && got.size() == 1 && hold < 3);
          if (!r) hold++;
        end
      endcase
      out_ready = r;
      if (busy && !out_valid && !pbnv) got_a.push_back(raddr);
      pbnv = busy && !out_valid;
      if (out_valid) begin
        if (r) got.push_back(out_data);
        else stalls++;
      end
      pv = out_valid; pd = out_data; phs = out_valid && r;
      if (done) begin
        seen = 1; done_cyc = cyc;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_at_done got=%b want=0", busy); end
      end
    end
    start = 0; out_ready = 1;
    exp_done = count == 0 ? 1 : 1 + 6 * count + stalls;
    checks++;
    if (done_cyc != exp_done) begin
      failures++;
      $display("FAIL done_cycle base=%0d count=%0d got=%0d want=%0d", base, count, done_cyc, exp_done);
    end
    checks++;
    bad = got.size() != exp_b.size();
    for (int i = 0; i < got.size() && i < exp_b.size(); i++) if (got[i] !== exp_b[i]) bad++;
    if (bad != 0) begin
      failures++;
      $display("FAIL byte_stream count=%0d got_bytes=%0d want_bytes=%0d wrong=%0d", count, got.size(), exp_b.size(), bad);
    end
    checks++;
    bad = got_a.size() != exp_a.size();
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) if (got_a[i] !== exp_a[i]) bad++;
    if (bad != 0) begin
      failures++;
      $display("FAIL raddr_seq count=%0d got_reads=%0d want_reads=%0d wrong=%0d", count, got_a.size(), exp_a.size(), bad);
    end
    checks++;
    if (checksum !== exp_sum) begin
      failures++;
      $display("FAIL checksum_done got=%h want=%h", checksum, exp_sum);
    end
    @(posedge clk); #1;
    checks++;
    if (checksum !== exp_sum || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_done got sum=%h done=%b busy=%b want sum=%h done=0 busy=0", checksum, done, busy, exp_sum);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; we = 0; out_ready = 1; base_addr = 0; word_count = 0; waddr = 0; wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (raddr !== 0 || out_data !== 0 || out_valid !== 0 || busy !== 0 || done !== 0 || checksum !== 0) begin
      failures++;
      $display("FAIL reset_values got raddr=%0d data=%h valid=%b busy=%b done=%b sum=%h want all 0",
               raddr, out_data, out_valid, busy, done, checksum);
    end
    rst_n = 1;
  endtask

  task automatic test_single();
    write_word(5, 32'h44332211);
    run_cmd(5, 1, 0, 0, dc);
    checks++;
    if (dc != 7 || checksum !== 8'hAA) begin
      failures++;
      $display("FAIL single_word got done_cyc=%0d sum=%h want 7 aa", dc, checksum);
    end
  endtask

  task automatic test_backpressure();
    run_cmd(5, 1, 2, 0, dc);
    checks++;
    if (dc != 10) begin failures++; $display("FAIL backpressure_done got=%0d want=10", dc); end
  endtask

  task automatic test_wrap();
    write_word(1023, 32'h000000FF);
    write_word(0, 32'h00000001);
    run_cmd(1023, 2, 0, 0, dc);
    checks++;
    if (checksum !== 8'h00) begin failures++; $display("FAIL wrap_sum got=%h want=00", checksum); end
  endtask

  task automatic test_zero_and_ignored_start();
    run_cmd($urandom_range(1023, 0), 0, 0, 0, dc);
    run_cmd($urandom_range(1023, 0), 4, 1, 1, dc);
  endtask

  task automatic test_reset_mid();
    start = 1; base_addr = 5; word_count = 1; out_ready = 1;
    repeat (4) begin @(posedge clk); #1; start = 0; end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      failures++;
      $display("FAIL second_byte got valid=%b data=%h want 1 22", out_valid, out_data);
    end
    rst_n = 0;
    @(posedge clk); #1;
    checks++;
    if (raddr !== 0 || out_data !== 0 || out_valid !== 0 || busy !== 0 || done !== 0 || checksum !== 0) begin
      failures++;
      $display("FAIL reset_mid got raddr=%0d data=%h valid=%b busy=%b done=%b sum=%h want all 0",
               raddr, out_data, out_valid, busy, done, checksum);
    end
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL no_done_after_reset cyc=%0d got done=%b valid=%b want 0 0", i, done, out_valid);
      end
      @(posedge clk); #1;
    end
    run_cmd(5, 1, 0, 0, dc);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) run_cmd($urandom_range(1023, 0), $urandom_range(8, 1), 1, 0, dc);
  endtask

  task automatic test_full_depth();
    run_cmd($urandom_range(1023, 0), 1024, 1, 0, dc);
  endtask

  initial begin
    test_reset();
    for (int a = 0; a < 1024; a++) write_word(a, $urandom);
    test_single();
    test_backpressure();
    test_wrap();
    test_zero_and_ignored_start();
    test_reset_mid();
    test_random();
    test_full_depth();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pinwheel_ram_dumper.md
# pinwheel_ram_dumper

Read-side initiator for the pinwheel 32x1024 data RAM. On a start command, it reads a block of consecutive words through the RAM's registered read port and serializes each word as four bytes, least-significant byte first, on a valid/ready byte stream. It sits between the RAM read port and the debug/UART transmit path. It also produces an 8-bit additive checksum of every byte it sends.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: RAM word-address width. Depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 32: RAM word width. Fixed at 4 bytes, and no other value is supported.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  command strobe. Sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first word address. Sampled with `start`.
- `word_count`  in  ADDR_WIDTH+1  number of words, 0..1024. Sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted start until DONE.
- `done`  out  1  one-cycle pulse when the command completes.
- `checksum`  out  8  sum of all sent bytes mod 256. Stable from `done` until the next accepted start.
- `raddr`  out  ADDR_WIDTH  RAM read address. Registered.
- `rdata`  in  DATA_WIDTH  RAM read data. Valid one cycle after `raddr` is presented.
- `out_data`  out  8  stream byte.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.

## Operation
- The state machine has five states: IDLE, READ, CAPTURE, SEND, DONE.
- **IDLE:**
  - If `start` and `word_count != 0`: latch `base_addr` into the address register, latch `word_count` into the remaining-word counter, clear `checksum`, go to READ.
  - If `start` and `word_count == 0`: clear `checksum`, go to DONE.
  - Otherwise stay in IDLE.
- **READ:** `raddr` holds the current address and the RAM samples it. Go to CAPTURE.
- **CAPTURE:**
  - Load `rdata` into the 32-bit shift register and set the byte index to 0.
  - Increment the address, wrapping 1023 to 0 (mod 2^ADDR_WIDTH).
  - Decrement the remaining-word counter.
  - Go to SEND.
- **SEND:**
  - `out_valid` is high and `out_data` is the shift register's low byte.
  - On a handshake (`out_valid && out_ready`):
    - add the byte to `checksum` (mod 256);
    - shift right by 8 and increment the byte index.
  - After the 4th handshake: go to READ if the remaining-word counter is nonzero, otherwise go to DONE.
- **DONE:** `done` is high for this one cycle. Go to IDLE.
- `start` in any state other than IDLE is ignored and has no side effects.
- **Stream rules:**
  - Once `out_valid` is asserted, it stays high and `out_data` stays stable until the handshake.
  - `out_valid` never depends combinationally on `out_ready`.
- `rdata` is used only in CAPTURE. Any other value it takes is ignored.

## Timing
- Reset values: state IDLE; `raddr`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `checksum`=0.
- A synchronous reset mid-operation aborts the command immediately: no `done` pulse, `out_valid` drops on the next edge, and partial bytes are lost.
- Latency from `start` sampled in cycle 0, with `out_ready` held high:
  - READ in cycle 1;
  - CAPTURE in cycle 2;
  - bytes handshake in cycles 3..6.
- Each word therefore takes 6 cycles. Every stall cycle with `out_ready` low adds 1 cycle.
- After the last handshake, `done` pulses in the next cycle and `busy` falls in that same cycle.
- With `word_count=0`: `start` in cycle 0 gives `done` in cycle 1, and no bytes are sent.
- `word_count=1024` reads every address exactly once, wrapping from `base_addr` back to `base_addr-1`.

## Structure
- Shared package `pinwheel_pkg` holds:
  - `ram_addr_t` (logic[9:0]);
  - `ram_word_t` (logic[31:0]);
  - the `dumper_state_e` enum.
- No sub-module. The block drives an externally instantiated `pinwheel_ram` read port. The bench instantiates `pinwheel_ram` directly and preloads it via its write port.

## Test plan
- **Single word:** preload addr 5 with 0x44332211; `start`, base=5, count=1, `out_ready`=1 → bytes 11,22,33,44 in cycles 3..6; `done` in cycle 7; `checksum`=0xAA.
- **Backpressure:** same preload; drop `out_ready` for 3 cycles while byte 0x22 is valid → 0x22 is held stable with `out_valid` high; sequence unchanged; `done` is 3 cycles later.
- **Wrap:** addr 1023=0x000000FF, addr 0=0x00000001; base=1023, count=2 → `raddr` shows 1023 then 0; bytes FF,00,00,00,01,00,00,00; `checksum`=0x00.
- **Zero count plus ignored start:** count=0 → `done` in cycle 1, no `out_valid`. A second `start` (base=0, count=4) issued while `busy` is ignored, so the transfer is unchanged.
- **Reset mid-transfer:** assert `rst_n`=0 during the second byte → next cycle all outputs are at reset values and no `done` pulse occurs. A fresh `start` afterwards completes normally.
